register_file: RTL and testbench
================================

Name: register_file

Overview:
- Multi-ported general-purpose register file for the 16-bit RISC datapath.
- 2^ADDR_WIDTH registers of DATA_WIDTH bits each; default 8 x 16.
- Two asynchronous (combinational) read ports and one synchronous write port.
- Sits between instruction decode, which supplies the register addresses, and ALU/writeback, which supply the operands and write data.

Parameters:
- DATA_WIDTH, 16, register width in bits.
- ADDR_WIDTH, 3, address width; register count = 2^ADDR_WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- RegWrite  input  1  write enable.
- read_reg_1  input  ADDR_WIDTH  read port 1 address.
- read_reg_2  input  ADDR_WIDTH  read port 2 address.
- write_reg  input  ADDR_WIDTH  write address.
- write_data  input  DATA_WIDTH  write data.
- read_data_1  output  DATA_WIDTH  contents of register read_reg_1.
- read_data_2  output  DATA_WIDTH  contents of register read_reg_2.

Interface note: one clock (clk); reset is asynchronous and active-low (rst_n).

Behaviour:
- Storage: array regs[0 .. 2^ADDR_WIDTH-1], each DATA_WIDTH bits.
- Reset: rst_n low immediately clears every register to 0, independent of clk.
  - Both read outputs then show 0 combinationally.
  - Reset dominates any write on the same edge.
  - Reset asserted mid-operation discards any pending write.
- Write: on posedge clk with rst_n high and RegWrite=1, regs[write_reg] <= write_data.
  - RegWrite=0 leaves all registers unchanged.
- Read: read_data_1 = regs[read_reg_1] and read_data_2 = regs[read_reg_2], purely combinational, zero-cycle latency.
  - Address changes propagate without a clock.
- No write-to-read bypass: while a write to register N is pending, a read of N returns the old value until the rising edge. The new value appears right after that edge.
- Both read ports may address the same register, including the one being written. Each port behaves independently with identical results.
- Full address range is valid; no out-of-range case exists. Addresses wrap naturally at ADDR_WIDTH bits.
- X/Z on write_reg while RegWrite=1 is illegal usage. The implementation need not define the result.
- No handshake and no state machine.

Optional Feature:
- Macro ZERO_REG_EN.
- Defined:
  - Register 0 is hardwired to zero; writes to address 0 are silently ignored.
  - Any read port addressing 0 returns 0.
- Undefined:
  - Register 0 is an ordinary read/write register, identical to the others.
  - Reset clears it to 0 like the rest.

Test Plan:
- Reset: hold rst_n=0 with RegWrite=1, write_reg=4, write_data=20 across a rising edge -> read_data_1 (reg 4) = 0, read_data_2 (reg 0) = 0.
- Basic write/read: release reset; RegWrite=1, write_reg=4, write_data=20, read_reg_1=4.
  - Before the edge: read_data_1 = 0.
  - After the first posedge: read_data_1 = 20.
- Write disable: RegWrite=0, write_reg=4, write_data=0xBEEF, one edge -> reg 4 still 20.
- Dual read and all registers: write reg k = 0x1000+k for k=0..7, then sweep both ports with independent addresses.
  - Every port returns the expected value, including both ports on the same address.
  - Register 0 returns 0x1000 without ZERO_REG_EN and 0 with it.
- Async reset mid-run: assert rst_n=0 between clock edges -> both outputs go to 0 before the next edge; all registers read 0 after release.
- Same-cycle read of the write target: read_reg_2=3, write reg 3 with 0x00AA while it holds 0x0055 -> read_data_2 = 0x0055 before the edge and 0x00AA after it.

Source files
------------

// File: rtl/register_file.sv
// Register file: 2^ADDR_WIDTH x DATA_WIDTH, two combinational read ports, one synchronous write port.
// Optional macro ZERO_REG_EN hardwires register 0 to zero.
module register_file #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] read_reg_1,
  input  logic [ADDR_WIDTH-1:0] read_reg_2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic [DATA_WIDTH-1:0] read_data_2
);

  localparam int unsigned NumRegs = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [NumRegs];
  logic                  w_write_en;

`ifdef ZERO_REG_EN
  // Writes to register 0 are dropped so it stays at its reset value of zero.
  assign w_write_en = RegWrite && (write_reg != '0);
`else
  assign w_write_en = RegWrite;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_write_en) begin
      r_regs[write_reg] <= write_data;
    end
  end

  // No write-to-read bypass: reads see the stored value until the write edge.
  always_comb begin
    read_data_1 = r_regs[read_reg_1];
    read_data_2 = r_regs[read_reg_2];
`ifdef ZERO_REG_EN
    if (read_reg_1 == '0) read_data_1 = '0;
    if (read_reg_2 == '0) read_data_2 = '0;
`endif
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed plan items plus randomized traffic
// compared against an array-based reference model.
module tb_register_file;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 3;
  localparam int unsigned NR = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          RegWrite;
  logic [AW-1:0] read_reg_1;
  logic [AW-1:0] read_reg_2;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data_1;
  logic [DW-1:0] read_data_2;

  int n_cmp;
  int n_err;

  logic [DW-1:0] model [NR];

  register_file #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RegWrite   (RegWrite),
    .read_reg_1 (read_reg_1),
    .read_reg_2 (read_reg_2),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_data_1(read_data_1),
    .read_data_2(read_data_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h @%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
`ifdef ZERO_REG_EN
    if (a == 0) return '0;
`endif
    return model[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NR; i++) model[i] = '0;
  endtask

  // Advance through a rising edge, apply the write to the model, then settle.
  task automatic step();
    @(posedge clk);
    if (rst_n && RegWrite) begin
`ifdef ZERO_REG_EN
      if (write_reg != 0) model[write_reg] = write_data;
`else
      model[write_reg] = write_data;
`endif
    end
    #1;
  endtask

  task automatic check_reads(input string tag);
    check({tag, "_rd1"}, read_data_1, model_rd(read_reg_1));
    check({tag, "_rd2"}, read_data_2, model_rd(read_reg_2));
  endtask

  task automatic sweep(input string tag);
    RegWrite = 1'b0;
    for (int a = 0; a < NR; a++) begin
      for (int b = 0; b < NR; b++) begin
        read_reg_1 = AW'(a);
        read_reg_2 = AW'(b);
        #1;
        check_reads(tag);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    model_clear();

    // Reset dominates a write on the same edge.
    rst_n      = 1'b0;
    RegWrite   = 1'b1;
    write_reg  = 3'd4;
    write_data = 16'd20;
    read_reg_1 = 3'd4;
    read_reg_2 = 3'd0;
    @(posedge clk);
    #1;
    check("rst_reg4", read_data_1, 16'd0);
    check("rst_reg0", read_data_2, 16'd0);

    // Basic write: old value before the edge, new value after.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("wr_pre", read_data_1, 16'd0);
    step();
    check("wr_post", read_data_1, 16'd20);

    // Write disable leaves contents unchanged.
    @(negedge clk);
    RegWrite   = 1'b0;
    write_data = 16'hBEEF;
    step();
    check("wr_dis", read_data_1, 16'd20);

    // Fill every register, then sweep both ports over all address pairs.
    for (int k = 0; k < NR; k++) begin
      @(negedge clk);
      RegWrite   = 1'b1;
      write_reg  = AW'(k);
      write_data = 16'h1000 + 16'(k);
      step();
    end
    @(negedge clk);
    RegWrite   = 1'b0;
    read_reg_1 = 3'd0;
    #1;
`ifdef ZERO_REG_EN
    check("reg0", read_data_1, 16'h0000);
`else
    check("reg0", read_data_1, 16'h1000);
`endif
    sweep("fill");

    // Asynchronous reset between edges clears outputs before the next edge.
    @(negedge clk);
    read_reg_1 = 3'd5;
    read_reg_2 = 3'd6;
    #1;
    check("pre_arst_rd1", read_data_1, 16'h1005);
    #1;
    rst_n = 1'b0;
    #1;
    model_clear();
    check("arst_rd1", read_data_1, 16'd0);
    check("arst_rd2", read_data_2, 16'd0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    sweep("post_arst");

    // Same-cycle read of the write target.
    @(negedge clk);
    RegWrite   = 1'b1;
    write_reg  = 3'd3;
    write_data = 16'h0055;
    step();
    @(negedge clk);
    read_reg_2 = 3'd3;
    write_data = 16'h00AA;
    #1;
    check("same_pre", read_data_2, 16'h0055);
    step();
    check("same_post", read_data_2, 16'h00AA);

    // Randomized traffic with occasional mid-cycle resets.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      RegWrite   = 1'($urandom_range(0, 1));
      write_reg  = AW'($urandom);
      write_data = DW'($urandom);
      read_reg_1 = AW'($urandom);
      read_reg_2 = ($urandom_range(0, 3) == 0) ? write_reg : AW'($urandom);
      #1;
      check_reads("rnd_pre");
      if ($urandom_range(0, 29) == 0) begin
        #1;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_reads("rnd_rst");
        #1;
        rst_n = 1'b1;
      end
      step();
      check_reads("rnd_post");
    end

    sweep("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
